// File: rtl/pinv_pkg.sv
// rtl/pinv_pkg.sv - shared constants, FSM states and row range check for the pseudoinverse row streamer
package pinv_pkg;

    localparam int ROWS          = 99;
    localparam int ROW_W         = 384;
    localparam int WORD_W        = 16;
    localparam int IDX_W         = 7;
    localparam int WORDS_PER_ROW = ROW_W / WORD_W;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic logic row_in_range(input int idx, input int nrows);
        return idx < nrows;
    endfunction

endpackage

// File: rtl/pinv_rr_arb.sv
// rtl/pinv_rr_arb.sv - combinational 2-way round-robin arbiter
module pinv_rr_arb (
    input  logic [1:0] req_valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/pinv_row_streamer.sv
// rtl/pinv_row_streamer.sv - arbitrates two row requests and streams the selected pseudoinverse row as words
module pinv_row_streamer #(
    parameter int ROWS   = pinv_pkg::ROWS,
    parameter int ROW_W  = pinv_pkg::ROW_W,
    parameter int WORD_W = pinv_pkg::WORD_W,
    parameter int IDX_W  = pinv_pkg::IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROWS*ROW_W-1:0]   rom_data,
    input  logic [1:0]              req_valid,
    input  logic [2*IDX_W-1:0]      req_row,
    output logic [1:0]              req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_data,
    output logic                    out_last,
    output logic                    out_id,
    output logic                    out_err
);

    import pinv_pkg::*;

    localparam int WORDS = ROW_W / WORD_W;
    localparam int CNT_W = $clog2(WORDS);
    localparam int OFF_W = $clog2(ROWS * ROW_W);

    state_t             state, state_d;
    logic               ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   beats;
    logic [ROW_W-1:0]   shift_reg;
    logic               id;
    logic               err;

    logic [1:0]         grant;
    logic               g;
    logic [IDX_W-1:0]   g_row;
    logic               g_ok;
    logic [OFF_W-1:0]   g_off;
    logic               accept;
    logic               beat_hs;
    logic               last_beat;

    pinv_rr_arb u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant)
    );

    // Out-of-range indices fall back to offset 0 so the part-select never leaves the bank.
    always_comb begin
        g     = grant[1];
        g_row = g ? req_row[2*IDX_W-1 -: IDX_W] : req_row[IDX_W-1:0];
        g_ok  = row_in_range(int'(g_row), ROWS);
        g_off = g_ok ? OFF_W'(g_row) * OFF_W'(ROW_W) : '0;
    end

    always_comb begin
        req_ready = (state == IDLE && !rst) ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        out_valid = (state == STREAM);
        beat_hs   = out_valid && out_ready;
        last_beat = out_valid && (cnt == beats - CNT_W'(1));
        out_last  = last_beat;
        out_data  = out_valid ? shift_reg[WORD_W-1:0] : '0;
        out_id    = out_valid & id;
        out_err   = out_valid & err;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = STREAM;
            STREAM:  if (beat_hs && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cnt       <= '0;
            beats     <= '0;
            shift_reg <= '0;
            id        <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                id  <= g;
                cnt <= '0;
                if (g_ok) begin
                    shift_reg <= rom_data[g_off +: ROW_W];
                    beats     <= CNT_W'(WORDS);
                    err       <= 1'b0;
                end else begin
                    shift_reg <= '0;
                    beats     <= CNT_W'(1);
                    err       <= 1'b1;
                end
            end else if (beat_hs) begin
                shift_reg <= shift_reg >> WORD_W;
                if (last_beat) begin
                    cnt <= '0;
                    ptr <= ~id;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pinv_row_streamer.sv
// tb/tb_pinv_row_streamer.sv - scoreboard bench for pinv_row_streamer
module tb_pinv_row_streamer;

    localparam int ROWS   = 99;
    localparam int ROW_W  = 384;
    localparam int WORD_W = 16;
    localparam int IDX_W  = 7;
    localparam int WORDS  = 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ROWS*ROW_W-1:0] rom_data;
    logic [1:0]            req_valid;
    logic [2*IDX_W-1:0]    req_row;
    logic [1:0]            req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_data;
    logic                  out_last;
    logic                  out_id;
    logic                  out_err;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        id;
        logic        err;
    } beat_t;

    beat_t exp_q[$];
    logic  grant_log[$];
    int    acc_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    hs_count = 0;
    bit    rdy_random = 0;
    bit    prev_stall = 0;
    beat_t held;

    pinv_row_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .rom_data  (rom_data),
        .req_valid (req_valid),
        .req_row   (req_row),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [15:0] pat(input int r, input int w);
        logic [6:0] rr;
        logic [7:0] ww;
        rr = 7'(r);
        ww = 8'(w);
        return {1'b1, rr, ww};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_row(input logic id, input int r);
        beat_t b;
        if (r >= ROWS) begin
            b = '{data: 16'h0, last: 1'b1, id: id, err: 1'b1};
            exp_q.push_back(b);
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                b = '{data: pat(r, w), last: (w == WORDS - 1), id: id, err: 1'b0};
                exp_q.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (out_valid) begin
            if (prev_stall) begin
                check("hold_data", 32'(out_data), 32'(held.data));
                check("hold_last", 32'(out_last), 32'(held.last));
                check("hold_id",   32'(out_id),   32'(held.id));
                check("hold_err",  32'(out_err),  32'(held.err));
            end
            if (out_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_data), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_last", 32'(out_last), 32'(e.last));
                    check("beat_id",   32'(out_id),   32'(e.id));
                    check("beat_err",  32'(out_err),  32'(e.err));
                end
            end
        end else begin
            check("idle_outputs", 32'({out_data, out_last, out_id, out_err}), 32'h0);
        end
        prev_stall = out_valid && !out_ready;
        held = '{data: out_data, last: out_last, id: out_id, err: out_err};
    end

    task automatic drive(input logic [1:0] mask, input logic [6:0] r0, input logic [6:0] r1,
                         input int ngrants, input bit hold);
        int got = 0;
        int n = 0;
        logic [1:0] acc;
        @(posedge clk);
        #1;
        req_row   = {r1, r0};
        req_valid = mask;
        while (got < ngrants && n < 500) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != 2'b00) begin
                check("grant_onehot", 32'(acc == 2'b01 || acc == 2'b10), 32'd1);
                grant_log.push_back(acc[1]);
                acc_cyc.push_back(cyc);
                got++;
            end
            @(posedge clk);
            #1;
            n++;
            if (!hold) req_valid = req_valid & ~acc;
        end
        req_valid = 2'b00;
        check("grant_count", 32'(got), 32'(ngrants));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_in_time", 32'(n < 3000), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int h0;
        int n;
        rom_data = '0;
        for (int r = 0; r < ROWS; r++)
            for (int w = 0; w < WORDS; w++)
                rom_data[r*ROW_W + w*WORD_W +: WORD_W] = pat(r, w);
        rst       = 1'b1;
        req_valid = 2'b01;
        req_row   = '0;
        out_ready = 1'b1;

        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;

        // single requester, row 0
        grant_log.delete();
        push_row(1'b0, 0);
        drive(2'b01, 7'd0, 7'd0, 1, 0);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_word0", 32'(out_data), 32'h8000);
        check("t1_id", 32'(out_id), 32'd0);
        wait_drain();

        // simultaneous requests after reset
        do_reset();
        grant_log.delete();
        acc_cyc.delete();
        push_row(1'b0, 5);
        push_row(1'b1, 98);
        drive(2'b11, 7'd5, 7'd98, 2, 0);
        wait_drain();
        check("t2_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t2_first_grant", 32'(grant_log[0]), 32'd0);
            check("t2_second_grant", 32'(grant_log[1]), 32'd1);
            check("t2_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd25);
        end

        // random stalls on row 42
        rdy_random = 1;
        h0 = hs_count;
        push_row(1'b0, 42);
        drive(2'b01, 7'd42, 7'd0, 1, 0);
        wait_drain();
        rdy_random = 0;
        check("t3_beats", 32'(hs_count - h0), 32'd24);

        // out-of-range row from requester 1
        h0 = hs_count;
        push_row(1'b1, 99);
        drive(2'b10, 7'd0, 7'd99, 1, 0);
        wait_drain();
        check("t4_beats", 32'(hs_count - h0), 32'd1);

        // reset in the middle of a stream
        h0 = hs_count;
        push_row(1'b0, 3);
        drive(2'b01, 7'd3, 7'd0, 1, 0);
        n = 0;
        while (hs_count - h0 < 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_reach_beat10", 32'(hs_count - h0), 32'd10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        check("t5_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;
        exp_q.delete();
        @(negedge clk);
        check("t5_after_rst_valid", 32'(out_valid), 32'd0);
        check("t5_after_rst_last", 32'(out_last), 32'd0);
        grant_log.delete();
        push_row(1'b0, 3);
        push_row(1'b1, 7);
        drive(2'b11, 7'd3, 7'd7, 2, 0);
        wait_drain();
        check("t5_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t5_ptr_reset_grant", 32'(grant_log[0]), 32'd0);
            check("t5_second_grant", 32'(grant_log[1]), 32'd1);
        end

        // both continuously valid: grants alternate
        grant_log.delete();
        push_row(1'b0, 10);
        push_row(1'b1, 20);
        push_row(1'b0, 10);
        push_row(1'b1, 20);
        drive(2'b11, 7'd10, 7'd20, 4, 1);
        wait_drain();
        check("t6_grants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check("t6_alternate", 32'(grant_log[i]), 32'(i % 2));
        end
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pinv_row_streamer.md
# pinv_row_streamer

Sequencer and 2-way arbiter for the precomputed pseudoinverse constant bank (99 rows × 384 bits, flat bus). Two OMP datapath requesters post a row index. The block grants one request at a time (round-robin), latches the selected 384-bit row, and streams it as 24 16-bit words over a valid/ready interface tagged with the requester ID. It sits between the pseudoinverse constant block and the projection MAC datapath.

## Interface
Parameters:
- ROWS, 99, number of pseudoinverse rows in the bank
- ROW_W, 384, bits per row
- WORD_W, 16, output word width; ROW_W must be a multiple of WORD_W
- IDX_W, 7, row index width; ceil(log2(ROWS))

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- rom_data  in  ROWS*ROW_W  flat constant bank; row r = bits [(r+1)*ROW_W-1 : r*ROW_W]
- req_valid  in  2  request valid, one bit per requester
- req_row  in  2*IDX_W  row index; requester i uses bits [(i+1)*IDX_W-1 : i*IDX_W]
- req_ready  out  2  request accept, one-hot or zero
- out_valid  out  1  output word valid
- out_ready  in  1  downstream ready
- out_data  out  WORD_W  current word
- out_last  out  1  final word of the current row
- out_id  out  1  requester that owns the current stream
- out_err  out  1  requested row index ≥ ROWS (error beat)

## Operation
- Two states: IDLE and STREAM.
- IDLE:
  - The arbiter picks the granted requester g among the asserted req_valid bits.
    - Priority pointer p: if both are valid, g = p; otherwise g = the single valid requester.
  - req_ready[g] = 1 combinationally in IDLE only when req_valid[g] = 1; req_ready is 0 in STREAM.
  - On accept (req_valid[g] & req_ready[g]):
    - Row index ≥ ROWS: latch err = 1, total beats = 1, shift register = 0, id = g.
    - Otherwise: latch the row into a ROW_W shift register, word counter = 0, total beats = ROW_W/WORD_W = 24, id = g, err = 0.
    - Go to STREAM.
- STREAM:
  - out_valid = 1.
  - out_data = shift_reg[WORD_W-1:0]; word 0 is the row LSBs.
  - out_last = (cnt == beats-1).
  - out_id and out_err are held for the whole stream.
  - On an out_valid & out_ready handshake: shift right by WORD_W and cnt++.
  - On the handshake of the last beat: go to IDLE, and set p = ~id (the other requester gets priority next).
- Holding rule: out_data, out_last, out_id and out_err stay stable while out_valid = 1 and out_ready = 0.
- No request is accepted during STREAM; a requester keeps req_valid and req_row stable until it sees req_ready.
- Outside STREAM, out_data, out_last, out_id and out_err are driven to 0.

## Timing
- Reset values: state = IDLE, p = 0, cnt = 0, shift register = 0. All outputs are 0, and req_ready = 0 during the reset cycle.
- Latency: request accepted at edge T → out_valid = 1 from cycle T+1 with word 0.
- With out_ready held at 1:
  - Last beat is in cycle T+24.
  - IDLE in cycle T+25; the next accept can occur at edge T+25.
  - Sustained throughput is 24 words per 25 cycles.
- Error request: exactly one beat with out_data = 0, out_last = 1, out_err = 1.
- Simultaneous requests: only g is accepted. The other requester is served right after the stream ends, through the pointer flip.
- Single requester repeating: it is re-granted every time regardless of p; p only matters on contention.
- rst asserted mid-STREAM: on the next edge the stream aborts. No out_last is emitted, all state returns to reset values, and the owner must re-request.
- cnt width is ceil(log2(24)) = 5 bits; it never exceeds beats-1.

## Structure
- Package pinv_pkg holds:
  - ROWS, ROW_W, WORD_W, IDX_W, and WORDS_PER_ROW = ROW_W/WORD_W.
  - The state enum {IDLE, STREAM}.
  - A row-index range check function.
- One sub-module, pinv_rr_arb: a 2-way round-robin arbiter.
  - Inputs: req_valid and pointer.
  - Outputs: one-hot grant.
  - Purely combinational; the pointer update stays in the top level.
- Row selection is an indexed part-select of rom_data by the latched index (ROWS:1 mux of ROW_W bits).

## Test plan
- Requester 0 requests row 0 with out_ready = 1 → 24 beats starting T+1: word 0 = rom_data[15:0], word 23 = rom_data[383:368], out_last only on beat 24, out_id = 0.
- Both request simultaneously after reset (row 5, row 98) → requester 0 is served first (row 5, 24 beats), then requester 1 (row 98, last word = rom_data[38015:38000]), with one IDLE cycle between the streams.
- Random out_ready stalls on row 42 → out_data, out_last and out_id hold during stalls; all 24 words arrive in order with none dropped or duplicated.
- Requester 1 requests row 99 (out of range) → one beat: out_err = 1, out_data = 0, out_last = 1, out_id = 1; then IDLE.
- rst asserted at beat 10 of a stream → outputs are 0 next cycle, state is IDLE, p = 0; a fresh request then restarts from word 0.
- Requester 0 continuously valid while requester 1 is also valid → grants alternate 0, 1, 0, 1 over four streams.
